// File: rtl/yarvi_uart_pkg.sv
// Shared UART definitions: serializer state encoding and the default baud divider.
package yarvi_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // 100 MHz system clock divided down to 115200 baud; the receiver uses the same value.
    localparam int DEFAULT_BAUD_DIV = 868;

endpackage

// File: rtl/yarvi_uart_tx_if.sv
// Byte handshake between the SoC (master) and the UART transmitter (slave).
interface yarvi_uart_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/yarvi_byte_fifo.sv
// Synchronous byte FIFO of 2**FIFO_LOG2 entries; extra pointer MSB distinguishes full from empty.
module yarvi_byte_fifo #(
    parameter int FIFO_LOG2 = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int PTR_W = FIFO_LOG2 + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]       mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[FIFO_LOG2] != rd_ptr_q[FIFO_LOG2]) &&
                      (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[FIFO_LOG2-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && do_push) mem_q[wr_ptr_q[FIFO_LOG2-1:0]] <= push_data;
    end

endmodule

// File: rtl/yarvi_uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer, or 8E1 when
// YARVI_UART_TX_PARITY_EN is defined.
module yarvi_uart_tx
    import yarvi_uart_pkg::*;
#(
    parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
    parameter int FIFO_LOG2 = 2
) (
    input  logic           clock,
    input  logic           reset,
    yarvi_uart_tx_if.slave in_if,
    output logic           txd,
    output logic           busy
);
    localparam int               CNT_W      = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BAUD_DIV - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
`ifdef YARVI_UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]       fifo_data;
    logic             bit_end, load;

    assign in_if.in_ready = !reset && !fifo_full;
    assign fifo_push      = in_if.in_valid && in_if.in_ready;
    assign fifo_pop       = load;
    assign bit_end        = (cnt_q == '0);
    assign txd            = txd_q;
    assign busy           = !fifo_empty || (state_q != ST_IDLE);

    yarvi_byte_fifo #(
        .FIFO_LOG2 (FIFO_LOG2)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (in_if.in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        load      = 1'b0;
`ifdef YARVI_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (state_q != ST_IDLE && !bit_end) cnt_d = cnt_q - CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                load  = !fifo_empty;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    txd_d     = shift_q[0];
                    bit_idx_d = '0;
                    cnt_d     = CNT_RELOAD;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = CNT_RELOAD;
                    if (bit_idx_q == 3'd7) begin
`ifdef YARVI_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        txd_d   = parity_q;
`else
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                    end
                end
            end
`ifdef YARVI_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    txd_d   = 1'b1;
                    cnt_d   = CNT_RELOAD;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (fifo_empty) begin
                        state_d = ST_IDLE;
                        txd_d   = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // Popping from IDLE or straight out of STOP both start a fresh frame with no gap.
        if (load) begin
            state_d  = ST_START;
            shift_d  = fifo_data;
            cnt_d    = CNT_RELOAD;
            txd_d    = 1'b0;
`ifdef YARVI_UART_TX_PARITY_EN
            parity_d = ^fifo_data;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
`ifdef YARVI_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
`ifdef YARVI_UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: doc/yarvi_uart_tx.md
# yarvi_uart_tx

Byte-stream UART transmitter that consumes the SoC's outgoing byte stream (the `tx_valid`/`tx_ready`/`tx_data` side of `yarvi_soc`) and serialises it onto a single-wire 8N1 line. It sits directly downstream of the SoC: the SoC drives the byte handshake, and this block buffers bytes in a small FIFO and shifts them out at a fixed baud rate. It replaces the tied-off transmit path in the simulation toplevel and is reused unchanged in FPGA builds.

## Interface

- `BAUD_DIV`, default 868: clock cycles per serial bit (100 MHz / 115200); legal range ≥ 2.
- `FIFO_LOG2`, default 2: log2 of FIFO depth (default 4 entries); legal range ≥ 1.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  SoC has a byte on `in_data`.
- `in_ready`  out  1  block can accept a byte this cycle.
- `in_data`  in  8  byte to transmit.
- `txd`  out  1  serial line; idle high.
- `busy`  out  1  FIFO non-empty or frame in progress.

## Operation

- Transfer occurs on a rising edge where `in_valid && in_ready`; the byte is written to the FIFO tail.
- `in_ready = !fifo_full`; no bypass path. A pop in the same cycle as full does not raise `in_ready` that cycle.
- Serializer FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
  - IDLE: `txd`=1. If FIFO non-empty: pop the head, load the shift register, go to START.
  - START: `txd`=0 for `BAUD_DIV` cycles, then DATA.
  - DATA: 8 bits, LSB first, each `BAUD_DIV` cycles; a 3-bit bit index counts 0..7, then PARITY or STOP.
  - STOP: `txd`=1 for `BAUD_DIV` cycles. At the end, if the FIFO is non-empty, pop and go directly to START (back-to-back, no idle gap); otherwise go to IDLE.
- Baud counter: width `$clog2(BAUD_DIV)`. Reloads to `BAUD_DIV-1` on entering each bit and counts down; the bit ends when it reaches 0.
- FIFO pointers are `FIFO_LOG2+1` bits wide and wrap naturally. Full means the MSBs differ and the LSBs are equal. Empty means the pointers are equal.
- `busy = !fifo_empty || state != IDLE`.

## Timing

- While `reset` is high and on the first edge after it: `txd`=1, `in_ready`=0, `busy`=0. The FIFO is cleared and the FSM is in IDLE.
- `in_ready`=1 from the first cycle after `reset` deasserts.
- Latency: a byte accepted at edge E0 into an empty FIFO with an IDLE serializer pops at E1. `txd` drops to 0 after E1.
- A frame lasts `10*BAUD_DIV` cycles, or `11*BAUD_DIV` with parity. `txd` changes only on bit boundaries and is driven from a register (glitch-free).
- `busy` rises the cycle after acceptance. It falls the cycle after the final stop bit completes, provided the FIFO is empty.
- Reset mid-frame: the frame is aborted, `txd`=1 on the next cycle, and queued bytes are discarded.
- Push and pop in the same cycle when the FIFO is not full: both take effect and the occupancy is unchanged.

## Configuration

- `YARVI_UART_TX_PARITY_EN` defined: a PARITY state is inserted between DATA and STOP. It outputs even parity (the XOR of the 8 data bits) for `BAUD_DIV` cycles. The frame format is 8E1.
- Not defined: the PARITY state and its logic are absent. The frame format is 8N1.

## Structure

- Shared package/include `yarvi_uart_pkg` holds:
  - the FSM state encoding constants (IDLE, START, DATA, PARITY, STOP);
  - the default `BAUD_DIV`, which the receiver shares.
- One sub-module: `yarvi_byte_fifo`, a parameterised synchronous FIFO with `FIFO_LOG2`, push/pop, and full/empty. It is reused by the planned `yarvi_uart_rx`.
- The top level contains the serializer FSM, the baud counter and the shift register.

## Test plan

All tests use `BAUD_DIV`=4 and `FIFO_LOG2`=2.

- Reset, then idle 20 cycles → `txd`=1, `busy`=0, `in_ready`=1 from the first post-reset cycle.
- Push 0x55 → `txd`=0 one edge after acceptance. Line sequence 0,1,0,1,0,1,0,1,0,1, each bit held exactly 4 cycles. `busy` falls 40 cycles after `txd` first falls.
- Hold `in_valid` high and push 0x01, 0x02, 0x03, 0x04, 0x05, 0x06 → `in_ready` drops once 4 bytes are queued. The bytes are transmitted back-to-back in order, with no idle cycles between stop and start. All 6 bytes are accepted.
- Assert `reset` 13 cycles into a frame of 0xA3 with 2 bytes queued → `txd`=1 the next cycle and `busy`=0. Nothing further is transmitted after `reset` releases.
- With `YARVI_UART_TX_PARITY_EN`: push 0x01 then 0x03 → frames are 44 cycles each. Parity bits are 1 and 0, followed by stop=1.
- Random valid toggling, 200 bytes → the decoded line stream equals the accepted byte stream. No byte is accepted while `in_ready`=0.
